wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 89 ++++++++
 tb/tb_wb_regfile.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback register file: 32x32 array, two combinational read ports and a pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile (
    input  logic        stg_clk,
    input  logic        reset,
    input  logic [4:0]  rd,
    input  logic [31:0] c,
    input  logic        save_to_reg,
    input  logic        stg_ena,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic        claim,
    input  logic [4:0]  claim_rd,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic        a_busy,
    output logic        b_busy
);

    logic [31:0] regs [32];
    logic [31:0] pending;
    logic [31:0] pend_next;
    logic        wr;
    logic        claim_act;
    logic [31:0] a_stored;
    logic [31:0] b_stored;

    // Gating with reset keeps the forwarding path quiet while reset is held.
    assign wr        = save_to_reg & ~stg_ena & (rd != 5'd0) & reset;
    assign claim_act = claim & (claim_rd != 5'd0) & reset;

    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr) begin
            regs[rd] <= c;
        end
    end

    // Claim is applied after the clear so a same-index claim/write leaves the bit set.
    always_comb begin
        pend_next = pending;
        if (wr) begin
            pend_next[rd] = 1'b0;
        end
        if (claim_act) begin
            pend_next[claim_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pend_next;
        end
    end

    assign a_stored = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign b_stored = (rs2 == 5'd0) ? '0 : regs[rs2];

`ifdef WB_REGFILE_BYPASS_EN
    always_comb begin
        a_out  = a_stored;
        a_busy = pending[rs1];
        b_out  = b_stored;
        b_busy = pending[rs2];
        if (wr && (rd == rs1)) begin
            a_out  = c;
            a_busy = claim_act && (claim_rd == rs1);
        end
        if (wr && (rd == rs2)) begin
            b_out  = c;
            b_busy = claim_act && (claim_rd == rs2);
        end
    end
`else
    always_comb begin
        a_out  = a_stored;
        a_busy = pending[rs1];
        b_out  = b_stored;
        b_busy = pending[rs2];
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; expectations follow WB_REGFILE_BYPASS_EN when it is defined.
module tb_wb_regfile;

    logic        stg_clk;
    logic        reset;
    logic [4:0]  rd;
    logic [31:0] c;
    logic        save_to_reg;
    logic        stg_ena;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        claim;
    logic [4:0]  claim_rd;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic        a_busy;
    logic        b_busy;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .stg_clk     (stg_clk),
        .reset       (reset),
        .rd          (rd),
        .c           (c),
        .save_to_reg (save_to_reg),
        .stg_ena     (stg_ena),
        .rs1         (rs1),
        .rs2         (rs2),
        .claim       (claim),
        .claim_rd    (claim_rd),
        .a_out       (a_out),
        .b_out       (b_out),
        .a_busy      (a_busy),
        .b_busy      (b_busy)
    );

    initial begin
        stg_clk = 1'b0;
        forever #5 stg_clk = ~stg_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge stg_clk);
        #1;
    endtask

    task automatic idle();
        save_to_reg = 1'b0;
        claim       = 1'b0;
        stg_ena     = 1'b0;
        rd          = 5'd0;
        c           = '0;
        claim_rd    = 5'd0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        rs1 = 5'd5;
        rs2 = 5'd0;
        #1;
        chk("reset_a_out", a_out, 32'h0);
        chk("reset_a_busy", {31'b0, a_busy}, 32'h0);
        step();
        reset = 1'b1;
        step();

        // write x5 and claim x5 in the same cycle
        rd = 5'd5; c = 32'hDEADBEEF; save_to_reg = 1'b1;
        claim = 1'b1; claim_rd = 5'd5;
        step();
        idle();
        #1;
        chk("x5_written", a_out, 32'hDEADBEEF);
        chk("x5_busy", {31'b0, a_busy}, 32'h1);
        // asynchronous reset pulse mid-cycle
        #2 reset = 1'b0;
        #1;
        chk("async_reset_a_out", a_out, 32'h0);
        chk("async_reset_a_busy", {31'b0, a_busy}, 32'h0);
        // write and claim held across an edge while in reset are discarded
        rd = 5'd5; c = 32'h11111111; save_to_reg = 1'b1;
        claim = 1'b1; claim_rd = 5'd5;
        step();
        idle();
        reset = 1'b1;
        #1;
        chk("write_in_reset_data", a_out, 32'h0);
        chk("write_in_reset_busy", {31'b0, a_busy}, 32'h0);

        // x0 is never written nor claimed
        rd = 5'd0; c = 32'hFFFFFFFF; save_to_reg = 1'b1;
        claim = 1'b1; claim_rd = 5'd0;
        rs1 = 5'd0;
        step();
        idle();
        #1;
        chk("x0_data", a_out, 32'h0);
        chk("x0_busy", {31'b0, a_busy}, 32'h0);

        // stall behaviour on x7
        rs1 = 5'd7;
        claim = 1'b1; claim_rd = 5'd7;
        step();
        idle();
        #1;
        chk("x7_claimed", {31'b0, a_busy}, 32'h1);
        rd = 5'd7; c = 32'h12345678; save_to_reg = 1'b1; stg_ena = 1'b1;
        #1;
        chk("stall_no_forward", a_out, 32'h0);
        step();
        #1;
        chk("stall_data", a_out, 32'h0);
        chk("stall_busy", {31'b0, a_busy}, 32'h1);
        stg_ena = 1'b0;
        step();
        idle();
        #1;
        chk("unstall_data", a_out, 32'h12345678);
        chk("unstall_busy", {31'b0, a_busy}, 32'h0);

        // claim/write collision on x3
        rs2 = 5'd3;
        rd = 5'd3; c = 32'hA5A5A5A5; save_to_reg = 1'b1;
        claim = 1'b1; claim_rd = 5'd3;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        chk("collide_pre_data", b_out, 32'hA5A5A5A5);
        chk("collide_pre_busy", {31'b0, b_busy}, 32'h1);
`else
        chk("collide_pre_data", b_out, 32'h0);
        chk("collide_pre_busy", {31'b0, b_busy}, 32'h0);
`endif
        step();
        idle();
        #1;
        chk("collide_data", b_out, 32'hA5A5A5A5);
        chk("collide_busy", {31'b0, b_busy}, 32'h1);
        chk("indep_a_data", a_out, 32'h12345678);
        chk("indep_a_busy", {31'b0, a_busy}, 32'h0);

        // plain write to x3 clears its pending bit
        rd = 5'd3; c = 32'h0BADF00D; save_to_reg = 1'b1;
        step();
        idle();
        #1;
        chk("x3_rewrite_data", b_out, 32'h0BADF00D);
        chk("x3_rewrite_busy", {31'b0, b_busy}, 32'h0);

        // bypass on x9, both read ports on the same index
        rd = 5'd9; c = 32'h00000011; save_to_reg = 1'b1;
        step();
        idle();
        rs1 = 5'd9; rs2 = 5'd9;
        rd = 5'd9; c = 32'h00000042; save_to_reg = 1'b1;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        chk("bypass_a_same", a_out, 32'h00000042);
        chk("bypass_b_same", b_out, 32'h00000042);
`else
        chk("bypass_a_same", a_out, 32'h00000011);
        chk("bypass_b_same", b_out, 32'h00000011);
`endif
        step();
        idle();
        #1;
        chk("bypass_a_next", a_out, 32'h00000042);
        chk("bypass_b_next", b_out, 32'h00000042);
        chk("bypass_busy_eq", {31'b0, b_busy}, {31'b0, a_busy});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
